// File: rtl/aim_line_drawer_if.sv
// rtl/aim_line_drawer_if.sv - request and VGA write-port bundle for the aim line drawer
//
// Request side : start, x0/y0 (pivot), x1/y1 (end point), color
// Plot side    : plot_x, plot_y, plot_color, plot (write strobe)
// Status       : busy (request in progress), done (one-cycle completion pulse)
// master drives the request and observes plots; slave is the drawer.
interface aim_line_drawer_if;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [2:0] color;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_color;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, x0, y0, x1, y1, color,
        input  plot_x, plot_y, plot_color, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, x1, y1, color,
        output plot_x, plot_y, plot_color, plot, busy, done
    );
endinterface

// File: rtl/aim_line_drawer.sv
// rtl/aim_line_drawer.sv - Bresenham aim line drawer with erase of the previous line
//
// clk    : rising-edge clock
// resetn : asynchronous active-low reset
// bus    : aim_line_drawer_if.slave (request in, VGA write port and status out)
// All outputs are registered, so they trail the state that produced them by one cycle.
module aim_line_drawer #(
    parameter logic [2:0] BG_COLOR = 3'b000,
    parameter bit         ERASE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    aim_line_drawer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP_E, ERASE, SETUP_D, DRAW, FINISH} state_t;
    state_t state, state_next;

    // latched request and the stored previous line
    logic [7:0] nx0, nx1, px0, px1;
    logic [6:0] ny0, ny1, py0, py1;
    logic [2:0] ncol;
    logic       prev_valid;

    // Bresenham state for the line being rasterised
    logic [7:0]        cx, xe, dx;
    logic [6:0]        cy, ye;
    logic signed [9:0] dy, err;
    logic              sx, sy;

    logic [7:0] plot_x_r;
    logic [6:0] plot_y_r;
    logic [2:0] plot_color_r;
    logic       plot_r, busy_r, done_r;

    assign bus.plot_x     = plot_x_r;
    assign bus.plot_y     = plot_y_r;
    assign bus.plot_color = plot_color_r;
    assign bus.plot       = plot_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

    // done is still high in the first IDLE cycle; a start there is dropped
    logic accept;
    assign accept = (state == IDLE) && bus.start && !done_r;

    // setup source: previous line for the erase pass, new line otherwise
    logic [7:0] s_xs, s_xe, s_dx;
    logic [6:0] s_ys, s_ye, s_ady;
    always_comb begin
        s_xs = nx0;
        s_ys = ny0;
        s_xe = nx1;
        s_ye = ny1;
        if (state == SETUP_E) begin
            s_xs = px0;
            s_ys = py0;
            s_xe = px1;
            s_ye = py1;
        end
        s_dx  = (s_xe >= s_xs) ? (s_xe - s_xs) : (s_xs - s_xe);
        s_ady = (s_ye >= s_ys) ? (s_ye - s_ys) : (s_ys - s_ye);
    end

    // one Bresenham step; e2 needs one bit more than err
    logic                at_end, step_x, step_y;
    logic signed [10:0]  e2, dx_ext, dy_ext;
    logic signed [9:0]   add_x, add_y, err_next;
    always_comb begin
        at_end   = (cx == xe) && (cy == ye);
        e2       = $signed({err, 1'b0});
        dx_ext   = $signed({3'b000, dx});
        dy_ext   = $signed({dy[9], dy});
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        add_x    = step_x ? dy : 10'sd0;
        add_y    = step_y ? $signed({2'b00, dx}) : 10'sd0;
        err_next = err + add_x + add_y;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = (ERASE_EN && prev_valid) ? SETUP_E : SETUP_D;
            SETUP_E: state_next = ERASE;
            ERASE:   if (at_end) state_next = SETUP_D;
            SETUP_D: state_next = DRAW;
            DRAW:    if (at_end) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nx0 <= '0; ny0 <= '0; nx1 <= '0; ny1 <= '0; ncol <= '0;
            px0 <= '0; py0 <= '0; px1 <= '0; py1 <= '0; prev_valid <= 1'b0;
            cx <= '0; cy <= '0; xe <= '0; ye <= '0; dx <= '0; dy <= '0;
            err <= '0; sx <= 1'b0; sy <= 1'b0;
            plot_x_r <= '0; plot_y_r <= '0; plot_color_r <= '0;
            plot_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0;
        end else begin
            plot_r <= (state == ERASE) || (state == DRAW);
            done_r <= (state == FINISH);
            if ((state == ERASE) || (state == DRAW)) begin
                plot_x_r     <= cx;
                plot_y_r     <= cy;
                plot_color_r <= (state == ERASE) ? BG_COLOR : ncol;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        nx0 <= bus.x0; ny0 <= bus.y0;
                        nx1 <= bus.x1; ny1 <= bus.y1;
                        ncol   <= bus.color;
                        busy_r <= 1'b1;
                    end
                end
                SETUP_E, SETUP_D: begin
                    cx  <= s_xs;
                    cy  <= s_ys;
                    xe  <= s_xe;
                    ye  <= s_ye;
                    dx  <= s_dx;
                    dy  <= -$signed({3'b000, s_ady});
                    err <= $signed({2'b00, s_dx}) - $signed({3'b000, s_ady});
                    sx  <= (s_xs < s_xe);
                    sy  <= (s_ys < s_ye);
                end
                ERASE, DRAW: begin
                    if (!at_end) begin
                        err <= err_next;
                        if (step_x) cx <= sx ? cx + 8'd1 : cx - 8'd1;
                        if (step_y) cy <= sy ? cy + 7'd1 : cy - 7'd1;
                    end
                end
                FINISH: begin
                    px0 <= nx0; py0 <= ny0;
                    px1 <= nx1; py1 <= ny1;
                    prev_valid <= 1'b1;
                    busy_r     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aim_line_drawer.sv
// tb/tb_aim_line_drawer.sv - scoreboard bench for aim_line_drawer
module tb_aim_line_drawer;
    logic clk;
    logic resetn;
    aim_line_drawer_if bus ();

    aim_line_drawer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [17:0] exp_q[$];

    // reference model of the previous line
    int pv_valid = 0;
    int pv_xs, pv_ys, pv_xe, pv_ye;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int line_len(input int xs, input int ys, input int xe, input int ye);
        int a, b;
        a = iabs(xe - xs);
        b = iabs(ye - ys);
        return ((a > b) ? a : b) + 1;
    endfunction

    // textbook Bresenham, one pixel pushed per plot
    task automatic push_line(input int xs, input int ys, input int xe, input int ye, input int col);
        int ddx, ddy, ssx, ssy, er, e2, x, y;
        ddx = iabs(xe - xs);
        ddy = -iabs(ye - ys);
        ssx = (xs < xe) ? 1 : -1;
        ssy = (ys < ye) ? 1 : -1;
        er  = ddx + ddy;
        x   = xs;
        y   = ys;
        for (int k = 0; k < 400; k++) begin
            exp_q.push_back({x[7:0], y[6:0], col[2:0]});
            if (x == xe && y == ye) break;
            e2 = 2 * er;
            if (e2 >= ddy) begin er += ddy; x += ssx; end
            if (e2 <= ddx) begin er += ddx; y += ssy; end
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bus.done) done_cnt++;
        if (resetn && bus.plot) begin
            if (exp_q.size() == 0) check("pix_extra", 1, 0);
            else check("pix", {14'd0, bus.plot_x, bus.plot_y, bus.plot_color}, {14'd0, exp_q.pop_front()});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        pv_valid = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // poke: cycle index at which to pulse start again (-1 none)
    // rst_at: cycle index at which to assert reset (-1 none)
    task automatic do_req(input int xs, input int ys, input int xe, input int ye, input int col,
                          input int poke, input int rst_at);
        int m, n, dstart, done_idx, d0;
        bit erase, exp_plot;
        erase = (pv_valid != 0);
        m = erase ? line_len(pv_xs, pv_ys, pv_xe, pv_ye) : 0;
        n = line_len(xs, ys, xe, ye);
        dstart   = erase ? m + 3 : 2;
        done_idx = dstart + n;
        if (erase) push_line(pv_xs, pv_ys, pv_xe, pv_ye, 0);
        push_line(xs, ys, xe, ye, col);
        d0 = done_cnt;

        @(negedge clk);
        bus.x0 = xs[7:0]; bus.y0 = ys[6:0];
        bus.x1 = xe[7:0]; bus.y1 = ye[6:0];
        bus.color = col[2:0];
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_at_k", bus.busy, 1);

        for (int idx = 0; idx <= done_idx; idx++) begin
            @(negedge clk);
            exp_plot = (idx >= 2 && idx < 2 + m) || (idx >= dstart && idx < dstart + n);
            check($sformatf("plot[%0d]", idx), bus.plot, exp_plot);
            check($sformatf("busy[%0d]", idx), bus.busy, (idx < done_idx));
            check($sformatf("done[%0d]", idx), bus.done, (idx == done_idx));
            if (idx == rst_at) begin
                #1 resetn = 1'b0;
                #1;
                check("rst_plot", bus.plot, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_xyc", {bus.plot_x, bus.plot_y, bus.plot_color}, 0);
                exp_q.delete();
                pv_valid = 0;
                @(negedge clk);
                check("rst_hold_plot", bus.plot, 0);
                resetn = 1'b1;
                return;
            end
            if (idx == poke) begin
                #1;
                bus.x0 = 8'd0; bus.y0 = 7'd0; bus.x1 = 8'd100; bus.y1 = 7'd50;
                bus.start = 1'b1;
            end
            if (idx == poke + 1) bus.start = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            check("post_plot", bus.plot, 0);
            check("post_done", bus.done, 0);
        end
        check("queue_empty", exp_q.size(), 0);
        check("done_once", done_cnt - d0, 1);
        pv_valid = 1;
        pv_xs = xs; pv_ys = ys; pv_xe = xe; pv_ye = ye;
    endtask

    initial begin
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.color = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.plot_x, bus.plot_y, bus.plot_color, bus.plot, bus.busy, bus.done}, 0);
        resetn = 1'b1;

        do_req(40, 100, 40, 100, 7, -1, -1);
        do_reset();
        do_req(40, 100, 45, 100, 2, -1, -1);
        do_req(40, 100, 42, 90, 5, -1, -1);
        do_reset();
        do_req(60, 64, 55, 59, 3, -1, -1);
        do_req(10, 10, 30, 17, 4, 12, -1);
        for (int r = 0; r < 4; r++)
            do_req($urandom_range(0, 159), $urandom_range(0, 119),
                   $urandom_range(0, 159), $urandom_range(0, 119),
                   $urandom_range(1, 7), -1, -1);
        do_reset();
        do_req(20, 20, 30, 25, 6, -1, 4);
        do_req(5, 5, 8, 3, 1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
